issue_tracker: RTL
==================

# issue_tracker

Parametrised in-order instruction tracker for the issue stage. It allocates a transaction ID per issued instruction and collects out-of-order results from NR_WB_PORTS writeback ports. It retires up to NR_COMMIT_PORTS completed instructions per cycle, in program order, and answers operand-clobber and forwarding queries for two source registers. It is the configurable successor to the fixed-geometry scoreboard, with multi-port commit, a youngest-writer forwarding search and occupancy reporting.

## Interface
- NR_ENTRIES, 8, tracker depth; power of two, ≥2. TID_W = $clog2(NR_ENTRIES).
- NR_WB_PORTS, 4, writeback ports.
- NR_COMMIT_PORTS, 2, commit ports; 1..NR_ENTRIES.
- XLEN, 64, result width.
- REG_ADDR_W, 5, register address width.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  discard all in-flight entries.
- issue_valid_i  in  1  new instruction offered.
- issue_ready_o  out  1  a slot is free and no flush is active.
- issue_rd_i  in  REG_ADDR_W  destination register.
- issue_we_i  in  1  instruction writes rd.
- issue_trans_id_o  out  TID_W  ID assigned on handshake; equals the tail index.
- wb_valid_i  in  NR_WB_PORTS  result strobe per port.
- wb_trans_id_i  in  NR_WB_PORTS×TID_W  target entry per port.
- wb_data_i  in  NR_WB_PORTS×XLEN  result data per port.
- wb_ex_i  in  NR_WB_PORTS  exception flag per port.
- commit_valid_o  out  NR_COMMIT_PORTS  entry head+k is ready to retire.
- commit_rd_o / commit_we_o / commit_data_o / commit_ex_o  out  per port  fields of entry head+k.
- commit_ack_i  in  NR_COMMIT_PORTS  retire acknowledge.
- rs_addr_i  in  2×REG_ADDR_W  source register query.
- rs_busy_o  out  2  an in-flight entry writes rs.
- rs_fwd_valid_o  out  2  the youngest writer of rs is done, without exception.
- rs_fwd_data_o  out  2×XLEN  result of the youngest writer.
- full_o, empty_o  out  1  occupancy flags.
- count_o  out  TID_W+1  number of occupied entries.

## Operation
- **Storage.** Circular buffer. Each entry holds {valid, rd, we, done, ex, data}. Head and tail pointers are TID_W+1 bits; the MSB is the wrap bit.
- **Full/empty.** full when the index bits are equal and the wrap bits differ. empty when head == tail.
- **Issue.**
  - issue_ready_o = !full_o & !flush_i.
  - On handshake: entry[tail] ← {1, rd, we, 0, 0, 0} and tail increments.
  - A slot freed by a commit in the same cycle is not reusable until the next cycle.
- **Writeback.**
  - For each port with wb_valid_i set, if entry[trans_id] is valid: set done, and capture data and ex.
  - A writeback to an invalid entry is ignored.
  - If several ports target the same ID in one cycle, the highest port index wins.
- **Commit.**
  - commit_valid_o[k] = entry[head+k].valid & done & commit_valid_o[k-1]. This is a prefix chain, driven from registered state only.
  - Retired count = the length of the contiguous prefix where ack[k] & valid[k] holds. An ack outside that prefix is ignored.
  - Retired entries are cleared and head advances by the retired count.
- **Query**, per source port:
  - rs_addr_i == 0 → busy = 0, fwd_valid = 0.
  - Otherwise, search for the youngest valid entry (the one closest to tail) with we and rd == rs_addr_i.
  - busy = found. fwd_valid = found & done & !ex. fwd_data = that entry's data, or 0 when nothing is found.
- **Flush.**
  - At the next edge: all entries are invalidated and head = tail = 0.
  - During the flush cycle: commit_valid_o is forced to 0, and issue, writeback and ack inputs are ignored.
- **Simultaneous events.** Issue, writeback and commit in the same cycle are all applied. Flush dominates everything except reset.
- **Reset (asynchronous).** Identical to flush state.
  - issue_ready_o = 1, issue_trans_id_o = 0, commit_valid_o = 0.
  - empty_o = 1, full_o = 0, count_o = 0.
  - rs_busy_o = 0, rs_fwd_valid_o = 0, all data outputs 0.
- **Count.** count_o = tail − head over TID_W+1 bits, modulo 2^(TID_W+1).

## Timing
- issue_trans_id_o and issue_ready_o are combinational from registered state and flush_i.
- **Issue at edge t:**
  - The entry is visible to the query outputs and count_o after t.
  - The earliest accepted writeback lands at edge t+1.
  - The earliest commit_valid_o is asserted in the cycle after that.
- **Writeback → visibility:** one cycle. There is no same-cycle bypass to commit or query outputs.
- **Ack at edge c:** the freed slots raise issue_ready_o in the cycle after c.
- Wrap-around is handled purely by pointer arithmetic; IDs repeat modulo NR_ENTRIES.
- Reset deasserts synchronously to clk_i at system level. No output depends combinationally on rst_i other than through the asynchronous state clear.

## Test plan
- **Fill and drain.** Defaults; issue 8 instructions rd=1..8 → IDs 0..7, full_o=1, issue_ready_o=0, count_o=8. Then write back IDs 0..7 and ack two per cycle → 4 commit cycles, empty_o=1.
- **Out-of-order writeback.** Issue 3 instructions; write back ID2 then ID0 → commit_valid_o=01 (ID0 only). Write back ID1 → next cycle commit_valid_o=11, covering ID1 and ID2.
- **Forwarding, youngest writer.** Issue rd=5 (ID0), then rd=5 (ID1); write back ID0 with 0xAA → query rs=5 gives busy=1, fwd_valid=0. Write back ID1 with 0xBB → fwd_valid=1, data=0xBB. A query of rs=0 always returns busy=0.
- **Same-port collision and ack filtering.** Ports 0 and 3 both write ID0, with 0x11 and 0x33 → commit_data_o[0]=0x33. commit_ack_i=10 with both ports valid → nothing retires.
- **Flush mid-operation with wrap.** With head=6 and 4 entries in flight across the wrap, assert flush_i for one cycle → commit_valid_o=0 during the flush, then empty_o=1 and the next issue_trans_id_o=0.
- **Reset mid-operation.** Assert rst_i asynchronously with 5 entries in flight → all outputs take their reset values immediately; a writeback on the first cycle after release is ignored.

Source files
------------

// File: rtl/issue_tracker.sv
// issue_tracker: in-order transaction tracker for the issue stage.
// Allocates a transaction ID per issued instruction, collects results from
// several writeback ports in any order, retires completed entries in program
// order over multiple commit ports and answers operand busy/forward queries.
module issue_tracker #(
    parameter int unsigned NR_ENTRIES      = 8,
    parameter int unsigned NR_WB_PORTS     = 4,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned REG_ADDR_W      = 5,
    parameter int unsigned TID_W           = $clog2(NR_ENTRIES)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  flush_i,
    input  logic                                  issue_valid_i,
    output logic                                  issue_ready_o,
    input  logic [REG_ADDR_W-1:0]                 issue_rd_i,
    input  logic                                  issue_we_i,
    output logic [TID_W-1:0]                      issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                wb_valid_i,
    input  logic [NR_WB_PORTS*TID_W-1:0]          wb_trans_id_i,
    input  logic [NR_WB_PORTS*XLEN-1:0]           wb_data_i,
    input  logic [NR_WB_PORTS-1:0]                wb_ex_i,
    output logic [NR_COMMIT_PORTS-1:0]            commit_valid_o,
    output logic [NR_COMMIT_PORTS*REG_ADDR_W-1:0] commit_rd_o,
    output logic [NR_COMMIT_PORTS-1:0]            commit_we_o,
    output logic [NR_COMMIT_PORTS*XLEN-1:0]       commit_data_o,
    output logic [NR_COMMIT_PORTS-1:0]            commit_ex_o,
    input  logic [NR_COMMIT_PORTS-1:0]            commit_ack_i,
    input  logic [2*REG_ADDR_W-1:0]               rs_addr_i,
    output logic [1:0]                            rs_busy_o,
    output logic [1:0]                            rs_fwd_valid_o,
    output logic [2*XLEN-1:0]                     rs_fwd_data_o,
    output logic                                  full_o,
    output logic                                  empty_o,
    output logic [TID_W:0]                        count_o
);

    localparam logic [TID_W:0] PTR_ONE = (TID_W+1)'(1);

    // Pointers carry one extra wrap bit above the slot index.
    logic [TID_W:0]            head_q, head_d, tail_q, tail_d;
    logic [NR_ENTRIES-1:0]     valid_q, valid_d;
    logic [NR_ENTRIES-1:0]     we_q, we_d;
    logic [NR_ENTRIES-1:0]     done_q, done_d;
    logic [NR_ENTRIES-1:0]     ex_q, ex_d;
    logic [REG_ADDR_W-1:0]     rd_q [NR_ENTRIES];
    logic [REG_ADDR_W-1:0]     rd_d [NR_ENTRIES];
    logic [XLEN-1:0]           data_q [NR_ENTRIES];
    logic [XLEN-1:0]           data_d [NR_ENTRIES];

    logic [TID_W-1:0]          head_idx, tail_idx;
    logic                      issue_hs;
    logic [NR_COMMIT_PORTS-1:0] cvalid;
    logic [NR_COMMIT_PORTS-1:0] retire_k;
    logic [TID_W:0]            n_retire;
    logic                      cchain, rchain;
    logic [TID_W-1:0]          c_idx, wb_id, ret_idx, q_idx, q_sel;
    logic [REG_ADDR_W-1:0]     q_addr;
    logic                      q_found;

    assign head_idx         = head_q[TID_W-1:0];
    assign tail_idx         = tail_q[TID_W-1:0];
    assign full_o           = (head_idx == tail_idx) && (head_q[TID_W] != tail_q[TID_W]);
    assign empty_o          = (head_q == tail_q);
    assign count_o          = tail_q - head_q;
    assign issue_ready_o    = !full_o && !flush_i;
    assign issue_trans_id_o = tail_idx;
    assign issue_hs         = issue_valid_i && issue_ready_o;
    assign commit_valid_o   = cvalid;

    // Commit window: prefix chain of valid+done entries starting at head.
    always_comb begin
        cchain        = 1'b1;
        c_idx         = '0;
        cvalid        = '0;
        commit_rd_o   = '0;
        commit_we_o   = '0;
        commit_data_o = '0;
        commit_ex_o   = '0;
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            c_idx     = head_idx + TID_W'(k);
            cchain    = cchain & valid_q[c_idx] & done_q[c_idx];
            cvalid[k] = cchain & ~flush_i;
            commit_rd_o[k*REG_ADDR_W +: REG_ADDR_W] = rd_q[c_idx];
            commit_we_o[k]                          = we_q[c_idx];
            commit_data_o[k*XLEN +: XLEN]           = data_q[c_idx];
            commit_ex_o[k]                          = ex_q[c_idx];
        end
    end

    // Retire only the contiguous acknowledged prefix; stray acks are dropped.
    always_comb begin
        rchain   = 1'b1;
        retire_k = '0;
        n_retire = '0;
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            rchain      = rchain & commit_ack_i[k] & cvalid[k];
            retire_k[k] = rchain;
            if (rchain) begin
                n_retire = n_retire + PTR_ONE;
            end
        end
    end

    // Next state: writeback, then retire clear, then issue into the tail slot.
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        done_d  = done_q;
        ex_d    = ex_q;
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        wb_id   = '0;
        ret_idx = '0;
        if (flush_i) begin
            valid_d = '0;
            we_d    = '0;
            done_d  = '0;
            ex_d    = '0;
            rd_d    = '{default: '0};
            data_d  = '{default: '0};
            head_d  = '0;
            tail_d  = '0;
        end else begin
            // Ascending port order lets the highest port win a collision.
            for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
                wb_id = wb_trans_id_i[p*TID_W +: TID_W];
                if (wb_valid_i[p] && valid_q[wb_id]) begin
                    done_d[wb_id] = 1'b1;
                    ex_d[wb_id]   = wb_ex_i[p];
                    data_d[wb_id] = wb_data_i[p*XLEN +: XLEN];
                end
            end
            for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
                ret_idx = head_idx + TID_W'(k);
                if (retire_k[k]) begin
                    valid_d[ret_idx] = 1'b0;
                    we_d[ret_idx]    = 1'b0;
                    done_d[ret_idx]  = 1'b0;
                    ex_d[ret_idx]    = 1'b0;
                    rd_d[ret_idx]    = '0;
                    data_d[ret_idx]  = '0;
                end
            end
            head_d = head_q + n_retire;
            // The tail slot is never a retiring slot: issue is blocked when full.
            if (issue_hs) begin
                valid_d[tail_idx] = 1'b1;
                we_d[tail_idx]    = issue_we_i;
                done_d[tail_idx]  = 1'b0;
                ex_d[tail_idx]    = 1'b0;
                rd_d[tail_idx]    = issue_rd_i;
                data_d[tail_idx]  = '0;
                tail_d            = tail_q + PTR_ONE;
            end
        end
    end

    // Operand query: walk head->tail so the last match is the youngest writer.
    always_comb begin
        rs_busy_o      = '0;
        rs_fwd_valid_o = '0;
        rs_fwd_data_o  = '0;
        q_addr         = '0;
        q_idx          = '0;
        q_sel          = '0;
        q_found        = 1'b0;
        for (int s = 0; s < 2; s++) begin
            q_addr  = rs_addr_i[s*REG_ADDR_W +: REG_ADDR_W];
            q_found = 1'b0;
            q_sel   = '0;
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                q_idx = head_idx + TID_W'(i);
                if ((q_addr != '0) && valid_q[q_idx] && we_q[q_idx] && (rd_q[q_idx] == q_addr)) begin
                    q_found = 1'b1;
                    q_sel   = q_idx;
                end
            end
            rs_busy_o[s]      = q_found;
            rs_fwd_valid_o[s] = q_found & done_q[q_sel] & ~ex_q[q_sel];
            if (q_found) begin
                rs_fwd_data_o[s*XLEN +: XLEN] = data_q[q_sel];
            end
        end
    end

    // State registers with asynchronous clear to the empty tracker.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            we_q    <= '0;
            done_q  <= '0;
            ex_q    <= '0;
            rd_q    <= '{default: '0};
            data_q  <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            done_q  <= done_d;
            ex_q    <= ex_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

endmodule
